// File: rtl/bf16_multiplier.sv
// Three-stage pipelined bfloat16 multiplier: flush-to-zero inputs, truncating
// mantissa, canonical NaN. Datapath advances every cycle; in_valid only tags out_valid.
module bf16_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        out_valid,
    output logic [15:0] result
);

    localparam int unsigned W  = 16;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 7;
    localparam int unsigned XW = 10;
    localparam int unsigned PW = 9;
    localparam logic signed [XW-1:0] BIAS    = 10'sd127;
    localparam logic signed [XW-1:0] EXP_MAX = 10'sd255;
    localparam logic [W-1:0]         QNAN    = 16'h7FC0;

    // Stage 1: input registers
    logic [W-1:0] a_q, b_q;
    logic         v1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            v1  <= 1'b0;
        end else begin
            a_q <= a;
            b_q <= b;
            v1  <= in_valid;
        end
    end

    // Stage 2: classify operands, mantissa product, biased exponent sum
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic          sign_c;
    logic [W-1:0]  prod_c;
    logic signed [XW-1:0] exp_c;
    logic          spec_c;
    logic [W-1:0]  spec_val_c;

    assign ea     = a_q[14:7];
    assign eb     = b_q[14:7];
    assign ma     = a_q[6:0];
    assign mb     = b_q[6:0];
    assign a_nan  = (&ea) &&  (|ma);
    assign b_nan  = (&eb) &&  (|mb);
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);
    assign sign_c = a_q[15] ^ b_q[15];
    assign prod_c = W'({1'b1, ma}) * W'({1'b1, mb});
    assign exp_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        spec_c     = 1'b0;
        spec_val_c = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_c     = 1'b1;
            spec_val_c = QNAN;
        end else if (a_inf || b_inf) begin
            spec_c     = 1'b1;
            spec_val_c = {sign_c, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_c     = 1'b1;
            spec_val_c = {sign_c, {EW{1'b0}}, {MW{1'b0}}};
        end
    end

    logic                 s2_sign, s2_spec, v2;
    logic [W-1:0]         s2_spec_val;
    logic [PW-1:0]        s2_prod;
    logic signed [XW-1:0] s2_exp;

    // Only product bits [15:7] can reach the truncated mantissa
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_sign     <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
            s2_prod     <= '0;
            s2_exp      <= '0;
            v2          <= 1'b0;
        end else begin
            s2_sign     <= sign_c;
            s2_spec     <= spec_c;
            s2_spec_val <= spec_val_c;
            s2_prod     <= prod_c[15:7];
            s2_exp      <= exp_c;
            v2          <= v1;
        end
    end

    // Stage 3: normalise, range check, special-case select
    logic signed [XW-1:0] norm_exp_c;
    logic [MW-1:0]        mant_c;
    logic [W-1:0]         res_c;

    assign norm_exp_c = s2_exp + $signed({{(XW-1){1'b0}}, s2_prod[PW-1]});
    assign mant_c     = s2_prod[PW-1] ? s2_prod[PW-2:1] : s2_prod[PW-3:0];

    always_comb begin
        res_c = {s2_sign, norm_exp_c[EW-1:0], mant_c};
        if (s2_spec) begin
            res_c = s2_spec_val;
        end else if (norm_exp_c >= EXP_MAX) begin
            res_c = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (norm_exp_c <= 10'sd0) begin
            res_c = {s2_sign, {EW{1'b0}}, {MW{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            result    <= res_c;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_bf16_multiplier.sv
// Scoreboard bench for bf16_multiplier: driver queues expected outputs per issued
// cycle, monitor pops and compares three edges later.
module tb_bf16_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_valid = 1'b0;
    logic        out_valid;
    logic [15:0] result;

    always #5 clk = ~clk;

    bf16_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .result    (result)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] r;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       issue = 1'b0;
    logic [2:0] live  = '0;

    logic [47:0] dir_vec [13] = '{
        48'h3F80_4000_4000, 48'hBF80_4000_C000, 48'h3F00_3F00_3E80,
        48'h3FC0_3FC0_4010, 48'h0000_3F80_0000, 48'h7F80_3F80_7F80,
        48'h7FC0_3F80_7FC0, 48'h0000_7F80_7FC0, 48'hFF80_3F80_FF80,
        48'h7F00_7F00_7F80, 48'h0080_0080_0000, 48'h8080_0080_8000,
        48'h0001_3F80_0000
    };

    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int  ex, ey, mx, my, p, e, m;
        bit  s, nx, ny, ix, iy, zx, zy;
        ex = int'(x[14:7]);  ey = int'(y[14:7]);
        mx = int'(x[6:0]);   my = int'(y[6:0]);
        s  = x[15] ^ y[15];
        nx = (ex == 255) && (mx != 0);  ny = (ey == 255) && (my != 0);
        ix = (ex == 255) && (mx == 0);  iy = (ey == 255) && (my == 0);
        zx = (ex == 0);                 zy = (ey == 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return 16'h7FC0;
        if (ix || iy) return {s, 15'h7F80};
        if (zx || zy) return {s, 15'h0000};
        p = (128 + mx) * (128 + my);
        e = ex + ey - 127;
        if (p >= 32768) begin
            m = (p / 256) % 128;
            e = e + 1;
        end else begin
            m = (p / 128) % 128;
        end
        if (e >= 255) return {s, 15'h7F80};
        if (e <= 0)   return {s, 15'h0000};
        return {s, 8'(e), 7'(m)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic v,
                         input logic [15:0] r);
        @(negedge clk);
        rst_n    = 1'b1;
        a        = x;
        b        = y;
        in_valid = v;
        exp_q.push_back('{v: v, r: r});
        issue    = 1'b1;
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n    = 1'b0;
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'b1;
            issue    = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n    = 1'b1;
            in_valid = 1'b0;
            issue    = 1'b0;
        end
    endtask

    // Monitor: reset clears in-flight work; otherwise pop once per issued cycle after 3 edges
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                live = '0;
                exp_q.delete();
                #1;
                chk("reset_result", result, 16'h0000);
                chk("reset_valid", 16'(out_valid), 16'h0000);
            end else begin
                live = {live[1:0], issue};
                #1;
                if (live[2]) begin
                    if (exp_q.size() == 0) begin
                        chk("queue_underflow", 16'h0001, 16'h0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_valid", 16'(out_valid), 16'(e.v));
                        chk("result", result, e.r);
                    end
                end else begin
                    chk("idle_valid", 16'(out_valid), 16'h0000);
                end
            end
        end
    end

    initial begin
        logic [15:0] x, y;
        hold_reset(4);

        for (int i = 0; i < 13; i++) begin
            logic [47:0] vrow;
            vrow = dir_vec[i];
            drive(vrow[47:32], vrow[31:16], 1'b1, vrow[15:0]);
        end

        for (int i = 0; i < 16; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            drive(x, y, (i % 2) == 0, ref_mul(x, y));
        end

        drive(16'h3F80, 16'h4000, 1'b1, 16'h4000);
        drive(16'h3FC0, 16'h3FC0, 1'b1, 16'h4010);
        hold_reset(2);
        drive(16'hBF80, 16'h4000, 1'b1, 16'hC000);
        drive(16'h7F00, 16'h7F00, 1'b1, 16'h7F80);

        for (int i = 0; i < 500; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            drive(x, y, 1'b0, ref_mul(x, y));
        end

        idle(5);
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
